// File: rtl/mux_2to1.sv
// Parameterised 2-to-1 mux with a combinational output and a registered copy.
// Y has zero latency; Y_q/sel_q capture the selection one clk after loading (en=1).
// No handshake: en=0 holds the registered copy, rst (async, active-high) clears it.
// Optional feature macro: MUX_2TO1_PARITY_EN adds registered even parity output par_q.
module mux_2to1 #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
`ifdef MUX_2TO1_PARITY_EN
    output logic             sel_q,
    output logic             par_q
`else
    output logic             sel_q
`endif
);

    // Conditional operator keeps an unknown select visible as X rather than
    // quietly picking one input; the whole word switches together.
    assign Y = sel ? B : A;

    // Registered copy of the mux result and its select; reset wins over everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_q   <= RESET_VAL;
            sel_q <= 1'b0;
        end else if (en) begin
            Y_q   <= Y;
            sel_q <= sel;
        end
    end

`ifdef MUX_2TO1_PARITY_EN
    // Even parity of the selected word, loaded and held alongside Y_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= ^RESET_VAL;
        end else if (en) begin
            par_q <= ^Y;
        end
    end
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: WIDTH=8 main instance plus WIDTH=1 sweep instance.
// Inputs change on the falling edge; registered outputs are sampled 1 ns after the rising edge.
// Optional parity checks follow the MUX_2TO1_PARITY_EN macro.
module tb_mux_2to1;

    logic       clk;
    logic       rst;
    logic [7:0] a8, b8;
    logic       sel8, en8;
    logic [7:0] y8, yq8;
    logic       selq8;
    logic       a1, b1, sel1, en1;
    logic       y1, yq1, selq1;
`ifdef MUX_2TO1_PARITY_EN
    logic       par8, par1;
`endif

    int checks = 0;
    int errors = 0;

    mux_2to1 #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .A     (a8),
        .B     (b8),
        .sel   (sel8),
        .en    (en8),
        .Y     (y8),
        .Y_q   (yq8),
`ifdef MUX_2TO1_PARITY_EN
        .sel_q (selq8),
        .par_q (par8)
`else
        .sel_q (selq8)
`endif
    );

    mux_2to1 #(.WIDTH(1), .RESET_VAL(1'b1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .A     (a1),
        .B     (b1),
        .sel   (sel1),
        .en    (en1),
        .Y     (y1),
        .Y_q   (yq1),
`ifdef MUX_2TO1_PARITY_EN
        .sel_q (selq1),
        .par_q (par1)
`else
        .sel_q (selq1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; en8 = 1'b1; en1 = 1'b0;
        a8 = 8'h5A; b8 = 8'hC3; sel8 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
        @(posedge clk); #1;
        checks++; if (yq8 !== 8'h00) begin errors++; $display("FAIL reset_yq8 got %h want 00", yq8); end
        checks++; if (selq8 !== 1'b0) begin errors++; $display("FAIL reset_selq8 got %b want 0", selq8); end
        checks++; if (yq1 !== 1'b1) begin errors++; $display("FAIL reset_yq1 got %b want 1", yq1); end
        checks++; if (y8 !== 8'hC3) begin errors++; $display("FAIL reset_y_tracks got %h want c3", y8); end
`ifdef MUX_2TO1_PARITY_EN
        checks++; if (par8 !== 1'b0) begin errors++; $display("FAIL reset_par8 got %b want 0", par8); end
        checks++; if (par1 !== 1'b1) begin errors++; $display("FAIL reset_par1 got %b want 1", par1); end
`endif
    endtask

    task automatic test_comb_sweep();
        logic [2:0] vec [8];
        logic       exp [8];
        vec = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
        exp = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            {a1, b1, sel1} = vec[i];
            #1;
            checks++;
            if (y1 !== exp[i]) begin
                errors++;
                $display("FAIL comb_sweep abs=%b got %b want %b", vec[i], y1, exp[i]);
            end
            #9;
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        rst = 1'b0; en8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; sel8 = 1'b0;
        #1;
        checks++; if (yq8 !== 8'h00) begin errors++; $display("FAIL load_no_early got %h want 00", yq8); end
        @(posedge clk); #1;
        checks++; if (yq8 !== 8'h5A) begin errors++; $display("FAIL load_a got %h want 5a", yq8); end
        checks++; if (selq8 !== 1'b0) begin errors++; $display("FAIL load_selq0 got %b want 0", selq8); end
        @(negedge clk);
        sel8 = 1'b1;
        #1;
        checks++; if (yq8 !== 8'h5A) begin errors++; $display("FAIL load_latency got %h want 5a", yq8); end
        checks++; if (y8 !== 8'hC3) begin errors++; $display("FAIL load_y_comb got %h want c3", y8); end
        @(posedge clk); #1;
        checks++; if (yq8 !== 8'hC3) begin errors++; $display("FAIL load_b got %h want c3", yq8); end
        checks++; if (selq8 !== 1'b1) begin errors++; $display("FAIL load_selq1 got %b want 1", selq8); end
    endtask

    task automatic test_hold();
        @(negedge clk);
        en8 = 1'b0; a8 = 8'h11; b8 = 8'h22; sel8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (yq8 !== 8'hC3) begin errors++; $display("FAIL hold_yq cyc%0d got %h want c3", i, yq8); end
            checks++; if (selq8 !== 1'b1) begin errors++; $display("FAIL hold_selq cyc%0d got %b want 1", i, selq8); end
            checks++; if (y8 !== 8'h11) begin errors++; $display("FAIL hold_y cyc%0d got %h want 11", i, y8); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (yq8 !== 8'h00) begin errors++; $display("FAIL async_rst_yq got %h want 00", yq8); end
        checks++; if (selq8 !== 1'b0) begin errors++; $display("FAIL async_rst_selq got %b want 0", selq8); end
        a8 = 8'h33;
        #1;
        checks++; if (y8 !== 8'h33) begin errors++; $display("FAIL async_rst_y got %h want 33", y8); end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1; en8 = 1'b1; sel8 = 1'b1; b8 = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (yq8 !== 8'h00) begin errors++; $display("FAIL rst_prio_yq cyc%0d got %h want 00", i, yq8); end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (yq8 !== 8'h00) begin errors++; $display("FAIL rst_release_hold got %h want 00", yq8); end
        @(posedge clk); #1;
        checks++; if (yq8 !== 8'hFF) begin errors++; $display("FAIL rst_release_load got %h want ff", yq8); end
        checks++; if (selq8 !== 1'b1) begin errors++; $display("FAIL rst_release_selq got %b want 1", selq8); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [4];
        logic [7:0] bv [4];
        logic       sv [4];
        logic [7:0] ev [4];
        av = '{8'h01, 8'hA5, 8'h7E, 8'h00};
        bv = '{8'h80, 8'h3C, 8'hFF, 8'h96};
        sv = '{1'b1, 1'b0, 1'b1, 1'b0};
        ev = '{8'h80, 8'hA5, 8'hFF, 8'h00};
        en8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a8 = av[i]; b8 = bv[i]; sel8 = sv[i];
            @(posedge clk); #1;
            checks++; if (yq8 !== ev[i]) begin errors++; $display("FAIL b2b_yq step%0d got %h want %h", i, yq8, ev[i]); end
            checks++; if (selq8 !== sv[i]) begin errors++; $display("FAIL b2b_selq step%0d got %b want %b", i, selq8, sv[i]); end
        end
    endtask

`ifdef MUX_2TO1_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        en8 = 1'b1; b8 = 8'h07; a8 = 8'h00; sel8 = 1'b1;
        @(posedge clk); #1;
        checks++; if (par8 !== 1'b1) begin errors++; $display("FAIL parity_b07 got %b want 1", par8); end
        @(negedge clk);
        a8 = 8'h03; sel8 = 1'b0;
        @(posedge clk); #1;
        checks++; if (par8 !== 1'b0) begin errors++; $display("FAIL parity_a03 got %b want 0", par8); end
        @(negedge clk);
        en8 = 1'b0; a8 = 8'h01;
        @(posedge clk); #1;
        checks++; if (par8 !== 1'b0) begin errors++; $display("FAIL parity_hold got %b want 0", par8); end
    endtask
`endif

    initial begin
        test_reset();
        test_comb_sweep();
        test_load();
        test_hold();
        test_async_reset();
        test_reset_priority();
        test_back_to_back();
`ifdef MUX_2TO1_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
